// File: rtl/frame_deser_pkg.sv
// Shared types and defaults for the frame deserialiser.
// Build option FRAME_DESER_PARITY_EN: each payload byte carries a trailing even-parity bit.
package frame_deser_pkg;

  typedef enum logic [0:0] {
    ST_HUNT    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  localparam logic [7:0]  DEF_SYNC_WORD = 8'hA5;
  localparam int unsigned DEF_FRAME_LEN = 4;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned BYTE_CNT_W = 8;

`ifdef FRAME_DESER_PARITY_EN
  localparam int unsigned BITS_PER_BYTE = 9;
`else
  localparam int unsigned BITS_PER_BYTE = 8;
`endif

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/frame_deser_if.sv
// Byte output handshake between frame_deser (master) and its consumer (slave).
// Build option FRAME_DESER_PARITY_EN does not affect this interface.
interface frame_deser_if;
  import frame_deser_pkg::*;

  logic [BYTE_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/frame_deser_bit_strobe.sv
// Rising-edge detector turning the recovered bit clock into a one-cycle bit strobe.
// Build option FRAME_DESER_PARITY_EN does not affect this block.
module bit_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_clk,
  output logic strobe_c
);

  logic bit_clk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_clk_q <= 1'b0;
    end else begin
      bit_clk_q <= bit_clk;
    end
  end

  assign strobe_c = bit_clk & ~bit_clk_q;

endmodule

// File: rtl/frame_deser.sv
// Hunts a sync word in the recovered bit stream and delivers FRAME_LEN payload bytes per frame.
// Build option FRAME_DESER_PARITY_EN: a ninth even-parity bit per byte, mismatches flagged on parity_err.
module frame_deser
  import frame_deser_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD = DEF_SYNC_WORD,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bit_clk,
  input  logic          bit_in,
  frame_deser_if.master bus,
  output logic          sync_lock,
  output logic          overrun,
  output logic          parity_err
);

  localparam logic [0:0] HUNT    = 1'(ST_HUNT);
  localparam logic [0:0] PAYLOAD = 1'(ST_PAYLOAD);

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BITS_PER_BYTE - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(FRAME_LEN - 1);

  logic                  strobe_c;

  logic [0:0]            state_q,      state_d;
  logic [BYTE_W-1:0]     shreg_q,      shreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q,   byte_cnt_d;
  logic [BYTE_W-1:0]     data_q,       data_d;
  logic                  valid_q,      valid_d;
  logic                  overrun_q,    overrun_d;
  logic                  parity_err_q, parity_err_d;

  logic [BYTE_W-1:0]     shifted_c;
  logic [BYTE_W-1:0]     byte_new_c;
  logic                  byte_done_c;
  logic                  par_bad_c;

  bit_strobe u_bit_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_clk  (bit_clk),
    .strobe_c (strobe_c)
  );

  assign shifted_c = {shreg_q[BYTE_W-2:0], bit_in};

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Next-state, byte assembly and output handshake.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    data_d       = data_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    parity_err_d = parity_err_q;
    byte_done_c  = 1'b0;
    byte_new_c   = shifted_c;
    par_bad_c    = 1'b0;

    case (state_q)
      HUNT: begin
        if (strobe_c) begin
          shreg_d = shifted_c;
          if (shifted_c == SYNC_WORD) begin
            state_d    = PAYLOAD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end
        end
      end
      PAYLOAD: begin
        if (strobe_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            byte_done_c = 1'b1;
`ifdef FRAME_DESER_PARITY_EN
            // Final strobe carries the parity bit; the byte is already in shreg.
            byte_new_c  = shreg_q;
            par_bad_c   = even_parity(shreg_q) ^ bit_in;
`endif
            shreg_d    = byte_new_c;
            bit_cnt_d  = '0;
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (byte_cnt_q == LAST_BYTE) begin
              state_d    = HUNT;
              shreg_d    = '0;
              byte_cnt_d = '0;
            end
          end else begin
            shreg_d   = shifted_c;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // A completing byte may replace one that is being consumed this cycle.
    if (byte_done_c) begin
      if (!valid_q || bus.ready) begin
        data_d  = byte_new_c;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      if (par_bad_c) begin
        parity_err_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.data   = data_q;
  assign bus.valid  = valid_q;
  assign sync_lock  = (state_q == PAYLOAD);
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_frame_deser.sv
// Self-checking bench for frame_deser: directed scenarios plus randomized frames against a reference model.
// Follows FRAME_DESER_PARITY_EN through frame_deser_pkg::BITS_PER_BYTE.
module tb_frame_deser;
  import frame_deser_pkg::*;

  localparam logic [7:0] SYNC = DEF_SYNC_WORD;
  localparam int         FLEN = DEF_FRAME_LEN;
  localparam int         BPB  = BITS_PER_BYTE;

  logic clk = 1'b0;
  logic rst_n;
  logic bit_clk;
  logic bit_in;
  logic sync_lock;
  logic overrun;
  logic parity_err;

  frame_deser_if bus_if ();

  frame_deser #(.SYNC_WORD(SYNC), .FRAME_LEN(FLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_clk    (bit_clk),
    .bit_in     (bit_in),
    .bus        (bus_if),
    .sync_lock  (sync_lock),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: bit-level frame parser plus a one-entry output holding slot.
  int         m_win, m_nbits, m_nbytes, m_acc;
  bit         m_lock, m_valid, m_overrun, m_perr, m_bc_prev;
  logic [7:0] m_data;
  int         rdy_mode;
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, 32'(acc_q.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < acc_q.size()) chk(tag, 32'(acc_q[i]), 32'(exp[i]));
    end
  endtask

  task automatic model_reset();
    m_win = 0; m_nbits = 0; m_nbytes = 0; m_acc = 0;
    m_lock = 0; m_valid = 0; m_overrun = 0; m_perr = 0; m_bc_prev = 0;
    m_data = 8'h00;
  endtask

  // One clock: compare against the model, drive inputs, then advance the model across the next edge.
  task automatic step(input logic bc, input logic bi);
    bit strobe, done, pbad;
    logic [7:0] nb;
    @(negedge clk);
    chk("sync_lock",  32'(sync_lock),     32'(m_lock));
    chk("valid",      32'(bus_if.valid),  32'(m_valid));
    chk("data",       32'(bus_if.data),   32'(m_data));
    chk("overrun",    32'(overrun),       32'(m_overrun));
    chk("parity_err", 32'(parity_err),    32'(m_perr));
    bit_clk = bc;
    bit_in  = bi;
    case (rdy_mode)
      0:       bus_if.ready = 1'b0;
      1:       bus_if.ready = 1'b1;
      default: bus_if.ready = 1'($urandom_range(0, 1));
    endcase
    if (bus_if.valid && bus_if.ready) acc_q.push_back(bus_if.data);

    strobe = bc && !m_bc_prev;
    m_bc_prev = bc;
    done = 0; pbad = 0; nb = 8'h00;
    if (strobe) begin
      if (!m_lock) begin
        m_win = (m_win * 2 + int'(bi)) % 256;
        if (m_win == int'(SYNC)) begin
          m_lock = 1; m_nbits = 0; m_nbytes = 0;
        end
      end else begin
        m_nbits++;
        if (m_nbits <= 8) m_acc = (m_acc * 2 + int'(bi)) % 256;
        else pbad = (($countones(8'(m_acc)) % 2) != int'(bi));
        if (m_nbits == BPB) begin
          done = 1; nb = 8'(m_acc); m_nbits = 0; m_nbytes++;
          if (m_nbytes == FLEN) begin
            m_lock = 0; m_win = 0;
          end
        end
      end
    end
    if (done) begin
      if (!m_valid || bus_if.ready) begin
        m_data = nb; m_valid = 1;
      end else begin
        m_overrun = 1;
      end
      if (pbad) m_perr = 1;
    end else if (m_valid && bus_if.ready) begin
      m_valid = 0;
    end
  endtask

  // Random high/low lengths exercise the edge detector, not just a fixed bit rate.
  task automatic send_bit(input logic b);
    int hi, lo;
    hi = int'($urandom_range(1, 4));
    lo = int'($urandom_range(1, 4));
    repeat (hi) step(1'b1, b);
    repeat (lo) step(1'b0, b);
  endtask

  task automatic send_bits8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bits8(b);
    if (BPB == 9) send_bit((^b) ^ bad_par);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset_async();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sync_lock",  32'(sync_lock),    32'h0);
    chk("rst_valid",      32'(bus_if.valid), 32'h0);
    chk("rst_data",       32'(bus_if.data),  32'h0);
    chk("rst_overrun",    32'(overrun),      32'h0);
    chk("rst_parity_err", 32'(parity_err),   32'h0);
    bit_clk = 1'b0;
    bit_in  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b2, last;
    logic       bits_q[$];
    logic [11:0] noise;

    rst_n = 1'b0; bit_clk = 1'b0; bit_in = 1'b0; bus_if.ready = 1'b1;
    rdy_mode = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_valid",     32'(bus_if.valid), 32'h0);
    chk("reset_data",      32'(bus_if.data),  32'h0);
    chk("reset_sync_lock", 32'(sync_lock),    32'h0);
    chk("reset_overrun",   32'(overrun),      32'h0);
    rst_n = 1'b1;

    // Basic frame, consumer always ready.
    acc_q.delete();
    send_bits8(SYNC);
    chk("s1_lock_after_sync", 32'(sync_lock), 32'h1);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b0);
    idle(4);
    chk("s1_lock_after_frame", 32'(sync_lock), 32'h0);
    exp_q = {8'h12, 8'h34, 8'h56, 8'h78};
    chk_acc("s1_bytes", exp_q);

    // Noise, then a trailing 0 so the hunt window momentarily reads 8'hA4, then the real marker.
    acc_q.delete();
    noise = 12'b0110_1101_0010;
    for (int i = 11; i >= 0; i--) send_bit(noise[i]);
    send_bit(1'b0);
    chk("s2_no_lock_noise", 32'(sync_lock), 32'h0);
    chk("s2_no_bytes_noise", 32'(acc_q.size()), 32'h0);
    send_bits8(SYNC);
    exp_q.delete();
    for (int i = 0; i < FLEN; i++) begin
      exp_q.push_back(8'($urandom));
      send_byte(exp_q[i], 1'b0);
    end
    idle(3);
    chk_acc("s2_bytes", exp_q);

    // Consumer stalled over bytes 1 and 2: byte 2 dropped, overrun sticks.
    acc_q.delete();
    rdy_mode = 0;
    send_bits8(SYNC);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    chk("s3_data_held", 32'(bus_if.data),  32'h12);
    chk("s3_valid_held", 32'(bus_if.valid), 32'h1);
    chk("s3_overrun",   32'(overrun),      32'h1);
    rdy_mode = 1;
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    idle(3);
    chk("s3_lock_end", 32'(sync_lock), 32'h0);
    chk("s3_overrun_sticky", 32'(overrun), 32'h1);
    exp_q = {8'h12, 8'h56, 8'h78};
    chk_acc("s3_bytes", exp_q);

    // Reset mid-frame after byte 2, then a clean frame.
    send_bits8(SYNC);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    do_reset_async();
    acc_q.delete();
    send_bits8(SYNC);
    exp_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (exp_q[i]) send_byte(exp_q[i], 1'b0);
    idle(3);
    chk_acc("s4_bytes", exp_q);
    chk("s4_overrun_clear", 32'(overrun), 32'h0);

    // Byte 2 completes in the very cycle byte 1 is accepted.
    acc_q.delete();
    rdy_mode = 0;
    send_bits8(SYNC);
    send_byte(8'h9A, 1'b0);
    b2 = 8'hBC;
    bits_q.delete();
    for (int i = 7; i >= 0; i--) bits_q.push_back(b2[i]);
    if (BPB == 9) bits_q.push_back(^b2);
    for (int i = 0; i < bits_q.size() - 1; i++) send_bit(bits_q[i]);
    last = {7'b0, bits_q[bits_q.size() - 1]};
    rdy_mode = 1;
    step(1'b1, last[0]);
    step(1'b1, last[0]);
    chk("s5_data_new",  32'(bus_if.data),  32'hBC);
    chk("s5_valid_kept", 32'(bus_if.valid), 32'h1);
    chk("s5_no_overrun", 32'(overrun),      32'h0);
    step(1'b0, last[0]);
    step(1'b0, last[0]);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle(3);
    exp_q = {8'h9A, 8'hBC, 8'h11, 8'h22};
    chk_acc("s5_bytes", exp_q);
    chk("s5_overrun_end", 32'(overrun), 32'h0);

`ifdef FRAME_DESER_PARITY_EN
    // Wrong parity on 8'h12: byte still delivered, error flag sticks.
    acc_q.delete();
    send_bits8(SYNC);
    send_byte(8'h12, 1'b1);
    chk("s6_parity_err", 32'(parity_err), 32'h1);
    send_byte(8'h34, 1'b0); send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b0);
    idle(3);
    exp_q = {8'h12, 8'h34, 8'h56, 8'h78};
    chk_acc("s6_bytes", exp_q);
    chk("s6_parity_sticky", 32'(parity_err), 32'h1);
`else
    send_bits8(SYNC);
    for (int i = 0; i < FLEN; i++) send_byte(8'($urandom), 1'b0);
    idle(3);
    chk("s6_parity_tied0", 32'(parity_err), 32'h0);
`endif

    // Randomized frames: noise, random ready, occasional bad parity; the model tracks everything.
    for (int f = 0; f < 10; f++) begin
      rdy_mode = int'($urandom_range(1, 2));
      repeat ($urandom_range(0, 20)) send_bit(1'($urandom));
      send_bits8(SYNC);
      for (int i = 0; i < FLEN; i++) send_byte(8'($urandom), 1'($urandom_range(0, 3) == 0));
      idle(int'($urandom_range(1, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_deser.md
FRAME_DESER -- requirements
Module: frame_deser

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5: frame marker hunted in the recovered bit stream.
REQ-002 Parameter FRAME_LEN, default 4: payload bytes per frame; legal range 1..255.
REQ-003 clk  input  1  single clock; same 8x oversampling clock that drives the upstream sampler.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 bit_clk  input  1  recovered bit clock from the sampler (clkout), synchronous to clk; each rising edge marks one new bit.
REQ-006 bit_in  input  1  recovered data bit from the sampler (out); stable when bit_clk rises.
REQ-007 data  output  8  payload byte, MSB received first.
REQ-008 valid  output  1  data holds an unconsumed byte.
REQ-009 ready  input  1  consumer accepts data when valid&&ready at a clk edge.
REQ-010 sync_lock  output  1  high while inside a frame (PAYLOAD state).
REQ-011 overrun  output  1  sticky: a completed byte was dropped.
REQ-012 parity_err  output  1  sticky: parity mismatch seen (tied 0 when parity compiled out).

Function
REQ-013 Bit strobe shall be bit_clk==1 && registered previous bit_clk==0; bit_in is captured only on strobe cycles; no other activity depends on bit_clk.
REQ-014 States: HUNT, PAYLOAD; reset state HUNT.
REQ-015 HUNT: on each strobe, 8-bit shift register shifts left with bit_in into LSB; if the post-shift value equals SYNC_WORD, next state is PAYLOAD with bit and byte counters at 0.
REQ-016 The sync word shall never be presented on data.
REQ-017 PAYLOAD: bits accumulate MSB-first; after 8 bits (9 with parity) a byte is complete and the byte counter increments.
REQ-018 A completed byte shall appear on data with valid=1 in the clk cycle after the completing strobe.
REQ-019 After byte FRAME_LEN completes, state shall return to HUNT with the hunt shift register cleared to 0.
REQ-020 sync_lock shall be 1 exactly when state is PAYLOAD.
REQ-021 valid shall fall in the cycle after valid&&ready, unless a new byte completes in that same cycle, in which case data takes the new byte and valid stays 1, no overrun.
REQ-022 If a byte completes while valid=1 and ready=0, the new byte shall be discarded, data unchanged, overrun set to 1.
REQ-023 data shall not change while valid=1 and ready=0.
REQ-024 Byte counting and return to HUNT proceed regardless of overrun.

Reset
REQ-025 While rst_n=0: state HUNT, counters 0, shift register 0, data=8'h00, valid=0, sync_lock=0, overrun=0, parity_err=0, registered bit_clk=0.
REQ-026 Reset asserted mid-frame shall abort the frame immediately; after release the block hunts afresh.
REQ-027 overrun and parity_err shall clear only on reset.

Configuration
REQ-028 Macro FRAME_DESER_PARITY_EN defined: each payload byte is followed by one even-parity bit (9 bits per byte); mismatch sets parity_err; byte still delivered.
REQ-029 Macro undefined: 8 bits per byte, no parity bit consumed, parity_err constant 0.

Structure
REQ-030 Package frame_deser_pkg shall hold the state enum type and the default SYNC_WORD and FRAME_LEN constants.
REQ-031 Sub-module bit_strobe shall contain the bit_clk edge register and the strobe output.

Verification
REQ-032 Bits 1010_0101 then bytes 8'h12,8'h34,8'h56,8'h78, ready=1 -> four valid pulses with data 12,34,56,78; sync_lock high from cycle after sync to cycle after byte 4.
REQ-033 Noise 0110_1101_0010 preceding sync -> no valid until after 8'hA5; false partial match (8'hA4) ignored.
REQ-034 ready=0 across bytes 1 and 2 -> data holds 8'h12, overrun=1; byte 2 lost; frame still ends after byte 4.
REQ-035 Byte completes in same cycle as valid&&ready -> data advances to new byte, valid stays 1, overrun stays 0.
REQ-036 rst_n low after byte 2 -> all outputs zero asynchronously; new frame after release delivered correctly.
REQ-037 FRAME_DESER_PARITY_EN defined, byte 8'h12 with parity bit 1 (wrong) -> data 8'h12 delivered, parity_err=1 and remains set.
